// File: rtl/ls_pkg.sv
// ls_pkg: shared FSM states and Local Storage geometry for the copy/fill engine.
package ls_pkg;
    typedef enum logic [2:0] {IDLE, CHECK, READ, WRITE, FINISH} state_t;
    localparam int LS_WORDS   = 4096;
    localparam int WORD_BYTES = 4;
endpackage

// File: rtl/ls_addr_gen.sv
// ls_addr_gen: read/write word pointers and remaining-word counter for one job.
module ls_addr_gen
    import ls_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_dir,
    input  logic [WIDTH-1:0] i_src,
    input  logic [WIDTH-1:0] i_dst,
    input  logic [CNTW-1:0]  i_count,
    output logic [WIDTH-1:0] o_rd_ptr,
    output logic [WIDTH-1:0] o_wr_ptr,
    output logic             o_last
);
    logic [WIDTH-1:0] r_rd, r_wr;
    logic [CNTW-1:0]  r_rem;
    logic             r_dir;
    logic [WIDTH-1:0] w_off, w_step;

    // Descending jobs start on the last word of each range.
    assign w_off  = WIDTH'({i_count - CNTW'(1), 2'b00});
    assign w_step = WIDTH'(WORD_BYTES);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_rem <= '0;
            r_dir <= 1'b0;
        end else if (i_load) begin
            r_dir <= i_dir;
            r_rd  <= i_dir ? i_src + w_off : i_src;
            r_wr  <= i_dir ? i_dst + w_off : i_dst;
            r_rem <= i_count;
        end else if (i_step) begin
            r_rd  <= r_dir ? r_rd - w_step : r_rd + w_step;
            r_wr  <= r_dir ? r_wr - w_step : r_wr + w_step;
            r_rem <= r_rem - CNTW'(1);
        end
    end

    assign o_rd_ptr = r_rd;
    assign o_wr_ptr = r_wr;
    assign o_last   = r_rem == CNTW'(1);
endmodule

// File: rtl/ls_copy_engine.sv
// ls_copy_engine: Local Storage copy/fill initiator on the single-port exmemory bus.
// Moore FSM; memory strobes decode directly from the state register.
module ls_copy_engine
    import ls_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNTW  = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fill,
    input  logic [WIDTH-1:0] src,
    input  logic [WIDTH-1:0] dst,
    input  logic [CNTW-1:0]  count,
    input  logic [WIDTH-1:0] pattern,
    output logic             memread,
    output logic             memwrite,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] memdata,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNTW-1:0]  words_done
);
    localparam int XW = WIDTH + CNTW + 2;

    state_t           r_state, w_next;
    logic             r_fill, r_err;
    logic [WIDTH-1:0] r_src, r_dst, r_pattern;
    logic [CNTW-1:0]  r_count, r_words;
    logic [XW-1:0]    w_s, w_d, w_e;
    logic             w_bad, w_desc, w_load, w_last;
    logic [WIDTH-1:0] w_rd_ptr, w_wr_ptr;

    // Overlap test is widened so src + 4*count can never wrap.
    assign w_s    = XW'(r_src);
    assign w_d    = XW'(r_dst);
    assign w_e    = w_s + XW'({r_count, 2'b00});
    assign w_bad  = (!r_fill && r_src[1:0] != 2'b00) || r_dst[1:0] != 2'b00 || r_count > CNTW'(LS_WORDS);
    assign w_desc = !r_fill && w_s < w_d && w_d < w_e;
    assign w_load = r_state == CHECK && !w_bad && r_count != '0;

    ls_addr_gen #(.WIDTH(WIDTH), .CNTW(CNTW)) u_addr_gen (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_step   (r_state == WRITE),
        .i_dir    (w_desc),
        .i_src    (r_src),
        .i_dst    (r_dst),
        .i_count  (r_count),
        .o_rd_ptr (w_rd_ptr),
        .o_wr_ptr (w_wr_ptr),
        .o_last   (w_last)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = start ? CHECK : IDLE;
            CHECK:   w_next = (w_bad || r_count == '0) ? FINISH : r_fill ? WRITE : READ;
            READ:    w_next = WRITE;
            WRITE:   w_next = w_last ? FINISH : r_fill ? WRITE : READ;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_fill    <= 1'b0;
            r_err     <= 1'b0;
            r_src     <= '0;
            r_dst     <= '0;
            r_pattern <= '0;
            r_count   <= '0;
            r_words   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && start) begin
                r_fill    <= fill;
                r_src     <= src;
                r_dst     <= dst;
                r_count   <= count;
                r_pattern <= pattern;
                r_words   <= '0;
                r_err     <= 1'b0;
            end
            if (r_state == CHECK) r_err <= w_bad;
            if (r_state == WRITE) r_words <= r_words + CNTW'(1);
        end
    end

    assign memread    = r_state == READ;
    assign memwrite   = r_state == WRITE;
    assign adr        = memread ? w_rd_ptr : memwrite ? w_wr_ptr : '0;
    assign writedata  = memwrite ? (r_fill ? r_pattern : memdata) : '0;
    assign busy       = r_state == CHECK || r_state == READ || r_state == WRITE;
    assign done       = r_state == FINISH;
    assign err        = done && r_err;
    assign words_done = r_words;
endmodule

// File: tb/tb_ls_copy_engine.sv
// tb_ls_copy_engine: table-driven check of ls_copy_engine against a behavioural exmemory.
module tb_ls_copy_engine;
    logic        clk = 0, reset = 1, start = 0, fill = 0;
    logic [31:0] src = 0, dst = 0, pattern = 0, adr, writedata, memdata = 0;
    logic [12:0] count = 0, words_done;
    logic        memread, memwrite, busy, done, err;
    logic [31:0] mem [4096];
    int          checks = 0, errors = 0;
    int          n_rd, n_wr, n_both, n_alt;
    logic        prev_rd, cur_fill;
    logic [31:0] first_wr, last_wr;

    typedef struct {
        logic        fill;
        logic [31:0] src, dst;
        logic [12:0] cnt;
        logic [31:0] pat, base;
        logic        err;
        int          lat;
        logic [31:0] first_wr, last_wr;
    } vec_t;
    vec_t vecs [10];

    ls_copy_engine dut (
        .clk(clk), .reset(reset), .start(start), .fill(fill), .src(src), .dst(dst),
        .count(count), .pattern(pattern), .memread(memread), .memwrite(memwrite),
        .adr(adr), .writedata(writedata), .memdata(memdata), .busy(busy),
        .done(done), .err(err), .words_done(words_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memread) memdata <= mem[adr[13:2]];
        if (memwrite) mem[adr[13:2]] <= writedata;
    end

    always @(negedge clk) begin
        if (memread && memwrite) n_both++;
        if (memread) n_rd++;
        if (memwrite) begin
            if (n_wr == 0) first_wr = adr;
            last_wr = adr;
            n_wr++;
            if (!cur_fill && !prev_rd) n_alt++;
        end
        prev_rd = memread;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int pulse_at, input logic [31:0] alt_dst);
        int          lat = 0, exp_wr;
        logic        got_err = 0;
        logic [11:0] idx;
        for (int i = 0; i < 4096; i++) mem[i] = v.base + i;
        exp_wr = (v.err || v.cnt == 0) ? 0 : int'(v.cnt);
        @(negedge clk);
        n_rd = 0; n_wr = 0; n_both = 0; n_alt = 0; prev_rd = 0; cur_fill = v.fill;
        fill = v.fill; src = v.src; dst = v.dst; count = v.cnt; pattern = v.pat; start = 1;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            start = 0;
            if (lat == 1) chk("busy_after_start", busy, 1);
            if (done) begin
                got_err = err;
                chk("words_at_done", words_done, exp_wr);
                break;
            end
            if (lat == pulse_at) begin
                start = 1; fill = 1; dst = alt_dst; count = 7; pattern = '1;
            end
        end
        #1;
        chk("latency", lat, v.lat);
        chk("err", got_err, v.err);
        chk("writes", n_wr, exp_wr);
        chk("reads", n_rd, v.fill ? 0 : exp_wr);
        chk("both_strobes", n_both, 0);
        chk("read_before_write", n_alt, 0);
        if (exp_wr > 0) begin
            chk("first_wr_adr", first_wr, v.first_wr);
            chk("last_wr_adr", last_wr, v.last_wr);
        end
        @(negedge clk);
        chk("done_one_cycle", {done, busy}, 0);
        chk("words_held", words_done, exp_wr);
        for (int j = 0; j < exp_wr; j++) begin
            idx = v.dst[13:2] + 12'(j);
            chk("ram_dst", mem[idx], v.fill ? v.pat : v.base + v.src[13:2] + j);
        end
        idx = v.dst[13:2] + 12'(exp_wr);
        chk("ram_guard", mem[idx], v.base + idx);
    endtask

    initial begin
        int lat;
        int act;
        vecs[0] = '{0, 32'h000, 32'h100, 13'd4,    0,            32'hA0,   0, 10, 32'h100, 32'h10C};
        vecs[1] = '{1, 32'h000, 32'h040, 13'd3,    32'hDEADBEEF, 0,        0, 5,  32'h040, 32'h048};
        vecs[2] = '{0, 32'h000, 32'h008, 13'd4,    0,            1,        0, 10, 32'h014, 32'h008};
        vecs[3] = '{0, 32'h000, 32'h102, 13'd4,    0,            0,        1, 2,  0,       0};
        vecs[4] = '{0, 32'h000, 32'h100, 13'd0,    0,            0,        0, 2,  0,       0};
        vecs[5] = '{0, 32'h001, 32'h200, 13'd2,    0,            0,        1, 2,  0,       0};
        vecs[6] = '{1, 32'h003, 32'h080, 13'd2,    32'h12345678, 0,        0, 4,  32'h080, 32'h084};
        vecs[7] = '{0, 32'h000, 32'h400, 13'd4097, 0,            0,        1, 2,  0,       0};
        vecs[8] = '{0, 32'h100, 32'h000, 13'd4,    0,            0,        0, 10, 32'h000, 32'h00C};
        vecs[9] = '{0, 32'h000, 32'h010, 13'd4,    0,            32'h1000, 0, 10, 32'h010, 32'h01C};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {memread, memwrite, adr, writedata, busy, done, err, words_done}, 0);
        reset = 0;
        for (int i = 0; i < 10; i++) run(vecs[i], -1, 0);
        // Start pulse while busy must not disturb the running copy.
        run(vecs[0], 3, 32'h300);
        chk("ignored_start_ram", mem[12'h0C0], vecs[0].base + 32'h0C0);
        // Reset during the second word of an 8-word copy.
        for (int i = 0; i < 4096; i++) mem[i] = 32'h50 + i;
        @(negedge clk);
        fill = 0; src = 0; dst = 32'h200; count = 8; start = 1;
        lat = 0;
        while (lat < 4) begin
            @(negedge clk);
            lat++;
            start = 0;
        end
        chk("mid_job_read", memread, 1);
        reset = 1;
        @(negedge clk);
        chk("abort_outputs", {memread, memwrite, adr, writedata, busy, done, err, words_done}, 0);
        reset = 0;
        n_rd = 0; n_wr = 0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) act++;
        end
        chk("no_done_after_abort", act, 0);
        chk("no_strobes_after_abort", n_rd + n_wr, 0);
        run(vecs[0], -1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
